// File: rtl/simpleuart_tx.sv
// -----------------------------------------------------------------------------
// simpleuart_tx
//
// Purpose:
//   Byte-oriented UART transmitter with a small transmit FIFO. Bytes are
//   queued through a valid/ready push interface and sent as 8N1 frames
//   (one start bit, eight data bits LSB first, one stop bit). The bit period
//   is latched from cfg_div when a byte is popped, so each frame is exactly
//   10*P clock cycles long. When another byte is waiting at the end of a
//   stop bit, the next start bit follows with no idle gap.
//
// Ports:
//   wb_clk_i    in   1   clock; all state changes on its rising edge
//   wb_rst_i    in   1   asynchronous active-high reset
//   cfg_div     in  16   bit period in clock cycles (values below 2 act as 2)
//   enable      in   1   permits new frames to start
//   in_data     in   8   byte to enqueue
//   in_valid    in   1   in_data is valid
//   in_ready    out  1   FIFO has room (registered state only)
//   ser_tx      out  1   serial line, idle high, driven from a flop
//   tx_busy     out  1   a frame is in progress
//   fifo_level  out  5   number of queued bytes, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module simpleuart_tx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] cfg_div,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ser_tx,
    output logic        tx_busy,
    output logic [4:0]  fifo_level
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ---------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_level;

    // ---------------------------------------------------------------------
    // Transmit FSM state
    // ---------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_period;   // bit period latched at the pop of this frame
    logic [15:0] r_cnt;      // cycle counter within the current bit
    logic [2:0]  r_bit_cnt;  // data bit index, 0..7
    logic [7:0]  r_shift;    // remaining data bits, current bit in [0]
    logic        r_ser_tx;
    logic        r_busy;

    logic        w_push;
    logic        w_pop;
    logic        w_bit_end;
    logic [15:0] w_period_sel;
    logic [7:0]  w_head;

    // in_ready depends only on the registered level, so a pop in the same
    // cycle never frees a slot combinationally.
    assign in_ready     = (r_level != DEPTH_L);
    assign w_push       = in_valid && in_ready;
    assign w_bit_end    = (r_cnt == (r_period - 16'd1));
    assign w_period_sel = (cfg_div < 16'd2) ? 16'd2 : cfg_div;

    // The head byte must be available in the pop cycle itself (the pop and
    // the shift-register load share one edge), hence the direct array read.
    assign w_head       = r_mem[r_rd_ptr];

    // A pop starts a frame either from idle or on the very last stop-bit
    // cycle, which is what gives back-to-back frames no idle gap.
    assign w_pop = enable && (r_level != 5'd0) &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    assign ser_tx     = r_ser_tx;
    assign tx_busy    = r_busy;
    assign fifo_level = r_level;

    // Storage is not reset; the pointers and level define which entries
    // are meaningful.
    always_ff @(posedge wb_clk_i) begin
        if (w_push && !wb_rst_i) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Transmit FSM with registered line and busy outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_period  <= 16'd2;
            r_cnt     <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_ser_tx  <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_pop) begin
            // Load the next frame: the start bit appears on the line from
            // the following cycle and lasts a full period.
            r_state   <= START;
            r_period  <= w_period_sel;
            r_cnt     <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= w_head;
            r_ser_tx  <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ser_tx <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cnt    <= 16'd0;
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt    <= 16'd0;
                        r_ser_tx <= r_shift[0];
                        r_state  <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= 16'd0;
                        if (r_bit_cnt == 3'd7) begin
                            r_ser_tx <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_ser_tx  <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    // The pop case is handled above; reaching the end of
                    // the stop bit here means nothing may start.
                    if (w_bit_end) begin
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_ser_tx <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simpleuart_tx.sv
// -----------------------------------------------------------------------------
// tb_simpleuart_tx
//
// Purpose:
//   Self-checking bench for simpleuart_tx. A queue of expected bytes and a
//   byte count model the FIFO; each frame on ser_tx is compared sample by
//   sample against the ideal 8N1 waveform built from the expected byte and
//   the bit period. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_simpleuart_tx;

    localparam int DEPTH = 8;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic [15:0] cfg_div;
    logic        enable;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ser_tx;
    logic        tx_busy;
    logic [4:0]  fifo_level;

    int checks;
    int errors;

    logic [7:0] exp_q[$];
    int         mlevel;

    simpleuart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cfg_div    (cfg_div),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_tx     (ser_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int floor_p(input logic [15:0] c);
        return (c < 16'd2) ? 2 : int'(c);
    endfunction

    // Assert reset asynchronously, check outputs without any clock edge,
    // then release on a falling edge.
    task automatic apply_reset();
        in_valid = 1'b0;
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if (ser_tx !== 1'b1) begin
            errors++; $display("FAIL reset_ser_tx got %b exp 1", ser_tx);
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy);
        end
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++; $display("FAIL reset_fifo_level got %0d exp 0", fifo_level);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        exp_q.delete();
        mlevel = 0;
    endtask

    // One push attempt lasting one clock; the model accepts when not full.
    task automatic push(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== (mlevel < DEPTH)) begin
            errors++;
            $display("FAIL push_in_ready byte %h got %b exp %b", d, in_ready, (mlevel < DEPTH));
        end
        if (mlevel < DEPTH) begin
            exp_q.push_back(d);
            mlevel++;
        end
        @(negedge wb_clk_i);
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 5'(mlevel)) begin
            errors++;
            $display("FAIL push_level byte %h got %0d exp %0d", d, fifo_level, mlevel);
        end
    endtask

    // Wait for a start bit, then compare 10*p samples with the ideal frame.
    // chg_at / drop_at change cfg_div / drop enable at that sample (-1: never).
    task automatic rx_frame(input logic [7:0] expb, input int p, input int chg_at,
                            input logic [15:0] chg_val, input int drop_at,
                            output int gap, output int lvl0);
        int         bad;
        int         busy_n;
        int         b;
        logic       found;
        logic       exp_lvl;
        logic [7:0] got;
        found  = 1'b0;
        gap    = 0;
        lvl0   = -1;
        bad    = 0;
        busy_n = 0;
        got    = 8'h00;
        for (int t = 0; t < 400; t++) begin
            @(negedge wb_clk_i);
            if (ser_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_start byte %h got no start bit exp start within 400 cycles", expb);
            return;
        end
        lvl0 = int'(fifo_level);
        for (int i = 0; i < 10 * p; i++) begin
            if (i > 0) @(negedge wb_clk_i);
            if (i == chg_at) cfg_div = chg_val;
            if (i == drop_at) enable = 1'b0;
            b = i / p;
            if (b == 0)      exp_lvl = 1'b0;
            else if (b == 9) exp_lvl = 1'b1;
            else             exp_lvl = expb[b-1];
            if (ser_tx !== exp_lvl) bad++;
            if ((b >= 1) && (b <= 8) && ((i % p) == (p / 2))) got[b-1] = ser_tx;
            if (tx_busy === 1'b1) busy_n++;
        end
        checks++;
        if ((bad != 0) || (got !== expb)) begin
            errors++;
            $display("FAIL frame_wave P=%0d got %h (%0d bad samples) exp %h", p, got, bad, expb);
        end
        checks++;
        if (busy_n != 10 * p) begin
            errors++;
            $display("FAIL frame_busy byte %h got %0d busy cycles exp %0d", expb, busy_n, 10 * p);
        end
    endtask

    // The line must stay high and not busy, with the modelled level.
    task automatic check_idle(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge wb_clk_i);
            if ((ser_tx !== 1'b1) || (tx_busy !== 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_idle got %0d non-idle cycles exp 0", name, bad);
        end
        checks++;
        if (fifo_level !== 5'(mlevel)) begin
            errors++;
            $display("FAIL %s_level got %0d exp %0d", name, fifo_level, mlevel);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        logic [7:0] e;
        int gap, lvl;
        cfg_div = 16'd4;
        enable  = 1'b1;
        push(8'h55);
        e = exp_q.pop_front();
        mlevel--;
        rx_frame(e, 4, -1, 16'd0, -1, gap, lvl);
        check_idle(20, "single");
        enable = 1'b0;
        $display("single byte 55 P=4 done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        int gap, lvl;
        enable  = 1'b0;
        cfg_div = 16'd8;
        push(8'hA3);
        push(8'h0F);
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            mlevel--;
            rx_frame(e, 8, -1, 16'd0, -1, gap, lvl);
            checks++;
            if ((gap != 0) || (lvl != mlevel)) begin
                errors++;
                $display("FAIL b2b_gap_level frame %0d got gap %0d level %0d exp gap 0 level %0d", k, gap, lvl, mlevel);
            end
        end
        check_idle(20, "b2b");
        enable = 1'b0;
        $display("back-to-back A3,0F P=8 done");
    endtask

    task automatic test_fifo_full();
        logic [7:0] e;
        int gap, lvl;
        enable  = 1'b0;
        cfg_div = 16'd2;
        for (int i = 1; i <= 9; i++) push(8'(i));
        enable = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mlevel--;
            rx_frame(e, 2, -1, 16'd0, -1, gap, lvl);
        end
        check_idle(40, "full");
        enable = 1'b0;
        $display("fifo full 01..09 done");
    endtask

    task automatic test_divisor_floor();
        logic [7:0] e;
        int gap, lvl;
        enable  = 1'b0;
        cfg_div = 16'd0;
        push(8'hFF);
        enable = 1'b1;
        e = exp_q.pop_front();
        mlevel--;
        rx_frame(e, 2, -1, 16'd0, -1, gap, lvl);
        check_idle(10, "floor0");
        cfg_div = 16'd1;
        push(8'h5A);
        e = exp_q.pop_front();
        mlevel--;
        rx_frame(e, 2, -1, 16'd0, -1, gap, lvl);
        check_idle(10, "floor1");
        enable = 1'b0;
        $display("divisor floor cfg_div 0 and 1 done");
    endtask

    task automatic test_reset_mid();
        logic found;
        enable  = 1'b0;
        cfg_div = 16'd4;
        push(8'h00);
        push(8'h00);
        push(8'h00);
        enable = 1'b1;
        found  = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge wb_clk_i);
            if (ser_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_start got no start bit exp start within 100 cycles");
        end
        // Sample 17 of the frame lies inside data bit 3.
        repeat (17) @(negedge wb_clk_i);
        checks++;
        if ((ser_tx !== 1'b0) || (tx_busy !== 1'b1)) begin
            errors++;
            $display("FAIL rstmid_bit3 got ser %b busy %b exp ser 0 busy 1", ser_tx, tx_busy);
        end
        #2;
        wb_rst_i = 1'b1;
        #1;
        checks++;
        if ((ser_tx !== 1'b1) || (fifo_level !== 5'd0) || (tx_busy !== 1'b0)) begin
            errors++;
            $display("FAIL rstmid_async got ser %b level %0d busy %b exp ser 1 level 0 busy 0", ser_tx, fifo_level, tx_busy);
        end
        // Pushes while reset is held must be ignored.
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        in_valid = 1'b0;
        wb_rst_i = 1'b0;
        exp_q.delete();
        mlevel = 0;
        check_idle(100, "rstmid");
        enable = 1'b0;
        $display("reset mid-frame done");
    endtask

    task automatic test_enable_drop();
        logic [7:0] e;
        int gap, lvl;
        enable  = 1'b0;
        cfg_div = 16'd4;
        push(8'hC6);
        push(8'h3B);
        enable = 1'b1;
        e = exp_q.pop_front();
        mlevel--;
        rx_frame(e, 4, -1, 16'd0, 12, gap, lvl);
        check_idle(60, "endrop");
        apply_reset();
        $display("enable drop done");
    endtask

    task automatic test_random();
        logic [7:0]  e;
        logic [15:0] newc;
        int gap, lvl, n, p, chg;
        logic first;
        for (int r = 0; r < 6; r++) begin
            enable  = 1'b0;
            cfg_div = 16'($urandom_range(0, 6));
            n       = int'($urandom_range(1, 10));
            for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)));
            enable = 1'b1;
            first  = 1'b1;
            while (exp_q.size() > 0) begin
                p = floor_p(cfg_div);
                e = exp_q.pop_front();
                mlevel--;
                chg  = first ? int'($urandom_range(0, 10 * p - 1)) : -1;
                newc = 16'($urandom_range(0, 6));
                rx_frame(e, p, chg, newc, -1, gap, lvl);
                checks++;
                if ((gap != 0) || (lvl != mlevel)) begin
                    errors++;
                    $display("FAIL rand_gap_level round %0d got gap %0d level %0d exp gap 0 level %0d", r, gap, lvl, mlevel);
                end
                first = 1'b0;
            end
            check_idle(25, "rand");
            enable = 1'b0;
            $display("random round %0d: %0d pushes done", r, n);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mlevel   = 0;
        wb_rst_i = 1'b0;
        cfg_div  = 16'd4;
        enable   = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        @(negedge wb_clk_i);
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_divisor_floor();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
